// File: rtl/arb_pkg.sv
// Shared definitions for the rotating-priority requester: default sizing,
// the client index type and the grant-vector shape check.
package arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_W_DEF   = 2;
  localparam int SEL_W_DEF   = $clog2(NUM_REQ_DEF);
  localparam int MAX_REQ     = 64;

  typedef logic [SEL_W_DEF-1:0] req_id_t;

  // True when at most one bit is set (popcount <= 1); callers zero-extend.
  function automatic logic onehot0(input logic [MAX_REQ-1:0] v);
    return (v & (v - MAX_REQ'(1))) == '0;
  endfunction

endpackage

// File: rtl/pend_counter.sv
// Saturating pending-request counter for one client. Simultaneous inc and dec
// cancel; inc at full is refused and reported on ovf in the same cycle.
module pend_counter
  import arb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic nonzero,
  output logic ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count;

  assign full    = (count == CNT_MAX);
  assign nonzero = (count != '0);
  assign ovf     = inc && !dec && full;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && nonzero) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Requester side of the rps arbiter: buffers client pulses, presents req/en/sel,
// validates the returned grant, reports accepted grants and flags violations.
module arb_requester
  import arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] issue,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] req,
  output logic               en,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] full,
  output logic               done_valid,
  output logic [SEL_W-1:0]   done_id,
  output logic               err
);

  // Handshake: req[i] is held while client i has pending work; the arbiter
  // answers in the same cycle with gnt. A grant is consumed only when en=1,
  // gnt is one-hot and targets a requesting client; gnt=0 is a legal stall.
  logic [NUM_REQ-1:0] nonzero;
  logic [NUM_REQ-1:0] ovf;
  logic [NUM_REQ-1:0] dec;
  logic [SEL_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               gnt_ok;
  logic               gnt_pend;
  logic               gnt_orphan;
  logic               acc;
  logic               viol;

  assign en  = enable;
  assign req = nonzero;

  assign gnt_any    = |gnt;
  assign gnt_ok     = onehot0(MAX_REQ'(gnt));
  assign gnt_pend   = |(gnt & nonzero);
  assign gnt_orphan = |(gnt & ~nonzero);
  assign acc        = enable && gnt_any && gnt_ok && gnt_pend;
  assign viol       = gnt_any && (!gnt_ok || !enable || gnt_orphan);
  assign dec        = acc ? gnt : '0;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = SEL_W'(i);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pend
    pend_counter #(.CNT_W(CNT_W)) u_pend (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (issue[g]),
      .dec     (dec[g]),
      .full    (full[g]),
      .nonzero (nonzero[g]),
      .ovf     (ovf[g])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sel        <= '0;
      done_valid <= 1'b0;
      done_id    <= '0;
      err        <= 1'b0;
    end else begin
      done_valid <= acc;
      if (acc) begin
        sel     <= sel + SEL_W'(1);
        done_id <= gnt_idx;
      end
      if (viol || (|ovf)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_arb_requester;
  import arb_pkg::*;

  localparam int N    = 4;
  localparam int MAXP = 3;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b1;
  logic [3:0] issue   = 4'hf;
  logic [3:0] gnt     = 4'h0;
  logic [3:0] req;
  logic [3:0] full;
  logic       en;
  logic [1:0] sel;
  logic       done_valid;
  req_id_t    done_id;
  logic       err;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  int m_pend[N] = '{0, 0, 0, 0};
  int m_sel = 0;
  int m_dv  = 0;
  int m_did = 0;
  int m_err = 0;

  arb_requester dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .issue      (issue),
    .enable     (enable),
    .gnt        (gnt),
    .req        (req),
    .en         (en),
    .sel        (sel),
    .full       (full),
    .done_valid (done_valid),
    .done_id    (done_id),
    .err        (err)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending counts per client, applied from the rules directly.
  always @(posedge clock) begin
    int  cnt;
    int  k;
    bit  viol;
    bit  legal;
    bit  granted;
    if (!reset_n) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_sel = 0; m_dv = 0; m_did = 0; m_err = 0;
    end else begin
      cnt = 0; k = 0; viol = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          cnt++;
          k = i;
          if (m_pend[i] == 0) viol = 1'b1;
        end
      end
      if (cnt > 1) viol = 1'b1;
      if (cnt != 0 && !enable) viol = 1'b1;
      legal = (cnt == 1) && enable && !viol;
      for (int i = 0; i < N; i++) begin
        granted = legal && (k == i);
        if (issue[i] && !granted) begin
          if (m_pend[i] == MAXP) viol = 1'b1;
          else m_pend[i]++;
        end else if (!issue[i] && granted) begin
          m_pend[i]--;
        end
      end
      m_dv = legal ? 1 : 0;
      if (legal) begin
        m_did = k;
        m_sel = (m_sel + 1) % N;
      end
      if (viol) m_err = 1;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clock) begin
    logic [3:0] e_req;
    logic [3:0] e_full;
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        e_req[i]  = (m_pend[i] != 0);
        e_full[i] = (m_pend[i] == MAXP);
      end
      chk("req", 32'(req), 32'(e_req));
      chk("full", 32'(full), 32'(e_full));
      chk("en", 32'(en), 32'(enable));
      chk("sel", 32'(sel), 32'(m_sel));
      chk("done_valid", 32'(done_valid), 32'(m_dv));
      chk("done_id", 32'(done_id), 32'(m_did));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  // driver tasks
  task automatic tick(input logic [3:0] iss, input logic ena, input logic [3:0] g);
    @(posedge clock);
    #1;
    issue  = iss;
    enable = ena;
    gnt    = g;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    issue   = 4'h0;
    gnt     = 4'h0;
    enable  = 1'b1;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int r;
    int k;
    logic [3:0] g;

    // 1. reset with issue held high
    @(posedge clock);
    #1 chk_on = 1'b1;
    @(negedge clock);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_dv", 32'(done_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    issue   = 4'b0101;
    tick(4'h0, 1'b1, 4'h0);
    @(negedge clock);
    chk("t1_req", 32'(req), 32'b0101);

    // 2. single accepted grant
    do_reset();
    tick(4'b0100, 1'b1, 4'h0);
    tick(4'h0, 1'b1, 4'b0100);
    tick(4'h0, 1'b1, 4'h0);
    @(negedge clock);
    chk("t2_dv", 32'(done_valid), 32'h1);
    chk("t2_id", 32'(done_id), 32'h2);
    chk("t2_sel", 32'(sel), 32'h1);
    chk("t2_req2", 32'(req[2]), 32'h0);
    chk("t2_err", 32'(err), 32'h0);

    // 3. fill, overflow, then issue+grant at full
    do_reset();
    repeat (3) tick(4'b0010, 1'b1, 4'h0);
    tick(4'h0, 1'b1, 4'h0);
    @(negedge clock);
    chk("t3_full", 32'(full[1]), 32'h1);
    chk("t3_err0", 32'(err), 32'h0);
    tick(4'b0010, 1'b1, 4'h0);
    tick(4'h0, 1'b1, 4'h0);
    @(negedge clock);
    chk("t3_ovf_err", 32'(err), 32'h1);
    chk("t3_ovf_full", 32'(full[1]), 32'h1);
    do_reset();
    repeat (3) tick(4'b0010, 1'b1, 4'h0);
    tick(4'b0010, 1'b1, 4'b0010);
    tick(4'h0, 1'b1, 4'h0);
    @(negedge clock);
    chk("t3_both_full", 32'(full[1]), 32'h1);
    chk("t3_both_err", 32'(err), 32'h0);
    chk("t3_both_dv", 32'(done_valid), 32'h1);
    chk("t3_both_id", 32'(done_id), 32'h1);

    // 4. protocol violations
    do_reset();
    tick(4'b0011, 1'b1, 4'h0);
    tick(4'h0, 1'b1, 4'b0011);
    tick(4'h0, 1'b1, 4'h0);
    @(negedge clock);
    chk("t4_multi_err", 32'(err), 32'h1);
    chk("t4_multi_dv", 32'(done_valid), 32'h0);
    chk("t4_multi_sel", 32'(sel), 32'h0);
    chk("t4_multi_req", 32'(req), 32'b0011);
    do_reset();
    tick(4'b0001, 1'b1, 4'h0);
    tick(4'h0, 1'b1, 4'b1000);
    tick(4'h0, 1'b1, 4'h0);
    @(negedge clock);
    chk("t4_orphan_err", 32'(err), 32'h1);
    chk("t4_orphan_dv", 32'(done_valid), 32'h0);
    do_reset();
    tick(4'b0001, 1'b1, 4'h0);
    tick(4'h0, 1'b0, 4'b0001);
    tick(4'h0, 1'b1, 4'h0);
    @(negedge clock);
    chk("t4_noen_err", 32'(err), 32'h1);
    chk("t4_noen_req", 32'(req), 32'b0001);

    // 5. four grants in a row, sel wraps
    do_reset();
    tick(4'b1111, 1'b1, 4'h0);
    tick(4'h0, 1'b1, 4'b0001);
    tick(4'h0, 1'b1, 4'b0010);
    @(negedge clock);
    chk("t5_id0", 32'(done_id), 32'h0);
    chk("t5_sel1", 32'(sel), 32'h1);
    tick(4'h0, 1'b1, 4'b0100);
    @(negedge clock);
    chk("t5_id1", 32'(done_id), 32'h1);
    chk("t5_sel2", 32'(sel), 32'h2);
    tick(4'h0, 1'b1, 4'b1000);
    @(negedge clock);
    chk("t5_id2", 32'(done_id), 32'h2);
    chk("t5_sel3", 32'(sel), 32'h3);
    tick(4'h0, 1'b1, 4'h0);
    @(negedge clock);
    chk("t5_id3", 32'(done_id), 32'h3);
    chk("t5_sel0", 32'(sel), 32'h0);
    chk("t5_dv", 32'(done_valid), 32'h1);
    chk("t5_req", 32'(req), 32'h0);

    // 6. stall then mid-operation reset
    do_reset();
    tick(4'b1111, 1'b1, 4'h0);
    tick(4'b0001, 1'b1, 4'b0001);
    repeat (3) tick(4'h0, 1'b1, 4'h0);
    @(negedge clock);
    chk("t6_stall_req", 32'(req), 32'b1111);
    chk("t6_stall_sel", 32'(sel), 32'h1);
    chk("t6_stall_dv", 32'(done_valid), 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("t6_rst_req", 32'(req), 32'h0);
    chk("t6_rst_sel", 32'(sel), 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // randomized traffic
    for (int cyc = 0; cyc < 2400; cyc++) begin
      if (cyc % 150 == 149 || $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 99);
        g = 4'h0;
        if (r < 60) begin
          k = $urandom_range(0, N - 1);
          for (int j = 0; j < N; j++) begin
            if (m_pend[(k + j) % N] != 0) begin
              k = (k + j) % N;
              break;
            end
          end
          g[k] = 1'b1;
        end else if (r >= 85) begin
          g = 4'($urandom_range(0, 15));
        end
        tick(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
             ($urandom_range(0, 9) != 0), g);
      end
    end
    tick(4'h0, 1'b1, 4'h0);
    @(negedge clock);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
